// File: rtl/decoded_inst_buffer.sv
// decoded_inst_buffer: one small FIFO per warp between the dual-packet decode
// stage and the issue scheduler. Accepts up to two in-order packets per cycle
// for one warp, exposes every warp's head to issue, pops one per cycle, exports
// per-warp room flags to fetch and supports per-warp flush.
// Optional feature macro: IBUF_BYPASS_EN (same-cycle bypass into an empty warp).

`ifndef NUM_WARP
`define NUM_WARP 8
`endif
`ifndef NUM_WARP_LOG
`define NUM_WARP_LOG 3
`endif
`ifndef LDST_SPACE_LOG
`define LDST_SPACE_LOG 2
`endif
`ifndef INST_TYPES_LOG
`define INST_TYPES_LOG 2
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_REGFILE
`define SIZE_REGFILE 6
`endif
`ifndef SIZE_OPCODE
`define SIZE_OPCODE 8
`endif
`ifndef SIZE_RP
`define SIZE_RP 4
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

module decoded_inst_buffer #(
    parameter int NUM_WARP = `NUM_WARP,
    parameter int DEPTH    = 4,
    parameter int PKT_W    = `LDST_SPACE_LOG+6+`INST_TYPES_LOG+`SIZE_IMMEDIATE+4*(`SIZE_REGFILE+1)+`SIZE_OPCODE+`SIZE_RP+1+3*`SIZE_PC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [`NUM_WARP_LOG-1:0] decodedWarp_i,
    input  logic                     decodedPacket0Valid_i,
    input  logic [PKT_W-1:0]         decodedPacket0_i,
    input  logic                     decodedPacket1Valid_i,
    input  logic [PKT_W-1:0]         decodedPacket1_i,
    input  logic                     issueReq_i,
    input  logic [`NUM_WARP_LOG-1:0] issueWarp_i,
    input  logic                     flush_i,
    input  logic [`NUM_WARP_LOG-1:0] flushWarp_i,
    output logic [NUM_WARP-1:0]      headValid_o,
    output logic [PKT_W-1:0]         headPacket_o,
    output logic [NUM_WARP-1:0]      warpRoom_o,
    output logic                     overflow_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WARP_W = `NUM_WARP_LOG;

    logic [PKT_W-1:0] r_mem   [NUM_WARP][DEPTH];
    logic [PTR_W-1:0] r_rptr  [NUM_WARP];
    logic [PTR_W-1:0] r_wptr  [NUM_WARP];
    logic [CNT_W-1:0] r_count [NUM_WARP];
    logic             r_overflow;

    logic [1:0]          w_num;
    logic [CNT_W:0]      w_need;
    logic                w_fits;
    logic                w_wrFlushed;
    logic                w_wrEn;
    logic                w_overflowNow;
    logic                w_popEn;
    logic [1:0]          w_storeNum;
    logic [PKT_W-1:0]    w_store0;
    logic [PKT_W-1:0]    w_store1;
    logic [PTR_W-1:0]    w_wrPtr;
    logic [PTR_W-1:0]    w_wrPtrNext;
    logic [NUM_WARP-1:0] w_wrHit;
    logic [NUM_WARP-1:0] w_popHit;
    logic [NUM_WARP-1:0] w_flushHit;
`ifdef IBUF_BYPASS_EN
    logic                w_bypassHit;
    logic                w_bypassPop;
`endif

    // Decide whether this cycle's write and pop happen, what gets stored and
    // where; room is judged on the registered count so a same-cycle pop never
    // makes space, and a flush of the target warp silently swallows both.
    always_comb begin
        w_num         = {1'b0, decodedPacket0Valid_i} + {1'b0, decodedPacket1Valid_i};
        w_need        = (CNT_W+1)'(r_count[decodedWarp_i]) + (CNT_W+1)'(w_num);
        w_fits        = (w_need <= (CNT_W+1)'(DEPTH));
        w_wrFlushed   = flush_i && (flushWarp_i == decodedWarp_i);
        w_wrEn        = (w_num != 2'd0) && w_fits && !w_wrFlushed;
        w_overflowNow = (w_num != 2'd0) && !w_fits && !w_wrFlushed;
        w_popEn       = issueReq_i && (r_count[issueWarp_i] != '0)
                        && !(flush_i && (flushWarp_i == issueWarp_i));
        w_wrPtr       = r_wptr[decodedWarp_i];
        w_wrPtrNext   = w_wrPtr + PTR_W'(1);
        w_store0      = decodedPacket0Valid_i ? decodedPacket0_i : decodedPacket1_i;
        w_store1      = decodedPacket1_i;
        w_storeNum    = w_wrEn ? w_num : 2'd0;
`ifdef IBUF_BYPASS_EN
        w_bypassHit   = w_wrEn && (r_count[decodedWarp_i] == '0);
        w_bypassPop   = w_bypassHit && issueReq_i && (issueWarp_i == decodedWarp_i);
        if (w_bypassPop) begin
            w_store0   = decodedPacket1_i;
            w_storeNum = w_num - 2'd1;
        end
`endif
        for (int w = 0; w < NUM_WARP; w++) begin
            w_wrHit[w]    = w_wrEn && (decodedWarp_i == WARP_W'(w));
            w_popHit[w]   = w_popEn && (issueWarp_i == WARP_W'(w));
            w_flushHit[w] = flush_i && (flushWarp_i == WARP_W'(w));
        end
    end

    // Per-warp pointer/count bookkeeping plus the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                r_rptr[w]  <= '0;
                r_wptr[w]  <= '0;
                r_count[w] <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow | w_overflowNow;
            for (int w = 0; w < NUM_WARP; w++) begin
                if (w_flushHit[w]) begin
                    r_rptr[w]  <= '0;
                    r_wptr[w]  <= '0;
                    r_count[w] <= '0;
                end else begin
                    r_wptr[w]  <= r_wptr[w] + (w_wrHit[w] ? PTR_W'(w_storeNum) : '0);
                    r_rptr[w]  <= r_rptr[w] + PTR_W'(w_popHit[w]);
                    r_count[w] <= r_count[w] + (w_wrHit[w] ? CNT_W'(w_storeNum) : '0)
                                  - CNT_W'(w_popHit[w]);
                end
            end
        end
    end

    // Packet storage; deliberately left out of reset since count gates validity.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            if (w_storeNum != 2'd0)
                r_mem[decodedWarp_i][w_wrPtr] <= w_store0;
            if (w_storeNum == 2'd2)
                r_mem[decodedWarp_i][w_wrPtrNext] <= w_store1;
        end
    end

    // Status flags from registered state and the head mux for the issue warp.
    always_comb begin
        for (int w = 0; w < NUM_WARP; w++) begin
            headValid_o[w] = (r_count[w] != '0);
            warpRoom_o[w]  = (r_count[w] <= CNT_W'(DEPTH - 2));
        end
        headPacket_o = r_mem[issueWarp_i][r_rptr[issueWarp_i]];
        overflow_o   = r_overflow;
`ifdef IBUF_BYPASS_EN
        if (w_bypassHit) begin
            headValid_o[decodedWarp_i] = 1'b1;
            if (issueWarp_i == decodedWarp_i)
                headPacket_o = decodedPacket0Valid_i ? decodedPacket0_i : decodedPacket1_i;
        end
`endif
    end

endmodule

// File: doc/decoded_inst_buffer.md
# decoded_inst_buffer

Per-warp instruction buffer directly downstream of the dual-packet decode stage; one buffer per warp. Each cycle it accepts up to two decoded packets for one warp, in program order, and queues them in that warp's FIFO. It presents the head packet of every warp to the issue scheduler and pops one packet per cycle. It exports per-warp room flags to fetch and supports per-warp flush on redirect.

## Interface
- `NUM_WARP`, default `` `NUM_WARP ``: number of warps, one FIFO each.
- `DEPTH`, default 4: entries per warp FIFO; power of two, minimum 2.
- `PKT_W`, default `` `LDST_SPACE_LOG+6+`INST_TYPES_LOG+`SIZE_IMMEDIATE+4*(`SIZE_REGFILE+1)+`SIZE_OPCODE+`SIZE_RP+1+3*`SIZE_PC ``: decoded packet width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `decodedWarp_i`  in  `` `NUM_WARP_LOG ``  warp of this cycle's packets.
- `decodedPacket0Valid_i`  in  1  packet 0 valid.
- `decodedPacket0_i`  in  PKT_W  older packet.
- `decodedPacket1Valid_i`  in  1  packet 1 valid.
- `decodedPacket1_i`  in  PKT_W  younger packet.
- `issueReq_i`  in  1  pop request.
- `issueWarp_i`  in  `` `NUM_WARP_LOG ``  warp to pop.
- `flush_i`  in  1  flush request.
- `flushWarp_i`  in  `` `NUM_WARP_LOG ``  warp to flush.
- `headValid_o`  out  NUM_WARP  bit w: warp w FIFO non-empty.
- `headPacket_o`  out  PKT_W  head entry of `issueWarp_i` (combinational mux).
- `warpRoom_o`  out  NUM_WARP  bit w: at least 2 free entries in warp w.
- `overflow_o`  out  1  sticky error flag.

## Operation
- State per warp: read pointer, write pointer (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits, range 0..DEPTH). Storage is NUM_WARP×DEPTH×PKT_W registers.
- Write count n = `decodedPacket0Valid_i` + `decodedPacket1Valid_i`.
  - If only packet 1 is valid, it is written alone.
  - If both are valid, packet 0 goes to wptr and packet 1 to wptr+1.
- Room check uses the registered count only; a same-cycle pop does not count. If count+n > DEPTH:
  - the whole write is dropped (no partial write);
  - `overflow_o` is set and stays 1 until reset.
- Pop: `issueReq_i` while `headValid_o[issueWarp_i]`=1 advances that warp's rptr by 1. A pop of an empty warp is ignored and is not an error.
- Push and pop on the same warp in the same cycle are both performed; count updates by n−1.
- Flush: `flush_i` zeroes count, rptr and wptr of `flushWarp_i`.
  - Flush beats a same-cycle write and a same-cycle pop on that warp; both are discarded with no overflow.
  - Other warps are unaffected.
- `headValid_o[w]` = (count[w] != 0). `warpRoom_o[w]` = (DEPTH − count[w] ≥ 2). Both derive from registered state only.
- Reset (asynchronous, mid-operation included) sets:
  - all counts and pointers to 0;
  - `headValid_o` to all 0;
  - `warpRoom_o` to all 1;
  - `overflow_o` to 0.
  - Storage is not cleared.

## Timing
- Write-to-visible latency is 1 cycle: packets written at edge N give `headValid_o` and `headPacket_o` at cycle N+1.
- Pop takes effect at the edge where `issueReq_i` is sampled. The next entry is visible in the following cycle.
- `warpRoom_o` drops in the cycle after the write that leaves fewer than 2 free entries.
- Fetch may launch a warp only while `warpRoom_o[w]`=1. The decode pipeline has no backpressure, so DEPTH must cover the fetch-to-buffer in-flight packets; overflow indicates a scheduler bug.
- No combinational path from `decodedPacket*` to any output (default build).

## Configuration
- `IBUF_BYPASS_EN`. When defined, a write to warp w with count[w]=0 and no same-cycle flush of w:
  - drives `headValid_o[w]`=1 in the same cycle;
  - drives `headPacket_o` (when `issueWarp_i`=w) from `decodedPacket0_i`, or from `decodedPacket1_i` if only packet 1 is valid.
  - A same-cycle pop consumes that packet: the older packet is never stored, and count ends at n−1.
  - This creates a combinational path from the decode inputs to the head outputs.
- When undefined: 1-cycle latency as above, with no bypass logic.

## Test plan
- Reset deassert, then write warp 2 with both packets valid (A, B), then pop warp 2 on two consecutive cycles → head A at cycle +1, then B; `headValid_o[2]` falls after the second pop; `warpRoom_o[2]` stays 1.
- DEPTH=4, write 2+2 to warp 0 → `warpRoom_o[0]`=0 and count 4. A third 1-packet write is dropped and `overflow_o`=1 sticky. Following pops return the original 4 in order.
- Write 1 packet per cycle to warp 1 for 6 cycles while popping every cycle → pointers wrap correctly, order is preserved, no overflow.
- Same-cycle write and flush on warp 3, while warp 4 holds 2 entries → warp 3 is empty afterwards with no overflow; warp 4 is untouched.
- Only packet 1 valid → it lands at the head. Then assert reset mid-stream with 3 entries queued → all outputs return to reset values asynchronously.
- With `IBUF_BYPASS_EN`, write C to empty warp 5 with a same-cycle pop → `headPacket_o`=C in that cycle; count stays 0.
